pipe_stage_register: RTL and testbench

- Parametrised successor to the plain N-bit pipeline register used between ASIP stages.
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, a synchronous flush, and a programmable reset value.
- Sits between any two vector-ASIP pipeline stages (e.g. decode→execute, execute→writeback).
- Lets a downstream stall propagate without combinational ready paths.

---
 rtl/pipe_stage_register.sv | 109 ++++++++++
 tb/tb_pipe_stage_register.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_register.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// in_ready comes from registered state only, so downstream stalls never form a combinational ready path.
module pipe_stage_register #(
   parameter int unsigned  N           = 8,
   parameter logic [N-1:0] RESET_VALUE = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic [1:0]   occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      FULL  = 2'b01,
      SKID  = 2'b10
   } state_t;

   state_t       state_q, state_d;
   logic [N-1:0] main_q, skid_q;
   logic         in_fire, out_fire;
   logic         load_main, main_from_skid, load_skid;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  load_main = 1'b1;
                  state_d   = FULL;
               end
            end
            FULL: begin
               if (in_fire && out_fire) begin
                  load_main = 1'b1;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end else if (in_fire) begin
                  load_skid = 1'b1;
                  state_d   = SKID;
               end
            end
            SKID: begin
               if (out_fire) begin
                  load_main      = 1'b1;
                  main_from_skid = 1'b1;
                  state_d        = FULL;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // NOTE: the storage registers are reset because RESET_VALUE is visible on out_data after reset.
   // Loads only happen on a handshake, so X on in_data while in_valid=0 never gets captured.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_q <= RESET_VALUE;
         skid_q <= RESET_VALUE;
      end else begin
         if (load_main) main_q <= main_from_skid ? skid_q : in_data;
         if (load_skid) skid_q <= in_data;
      end
   end

   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      occupancy = 2'd0;
      case (state_q)
         FULL: begin
            out_valid = 1'b1;
            occupancy = 2'd1;
         end
         SKID: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
            occupancy = 2'd2;
         end
         default: ;
      endcase
   end

   assign out_data = main_q;

endmodule

// File: tb/tb_pipe_stage_register.sv
// Self-checking bench: directed scenarios plus randomised traffic against a queue-based scoreboard.
// The monitor predicts the held entries from the handshake rules and checks them on every falling edge.
module tb_pipe_stage_register;

   localparam int unsigned  N  = 32;
   localparam logic [N-1:0] RV = 32'h0000_00A5;

   logic         clk = 1'b0;
   logic         reset;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;
   logic [1:0]   occupancy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [N-1:0] sb[$];
   bit           m_in_fire, m_out_fire;

   always #5 clk = ~clk;

   pipe_stage_register #(.N(N), .RESET_VALUE(RV)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [N-1:0] d, input logic r, input logic f);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
   endtask

   // Monitor: the stage is a FIFO of depth 2; compare DUT view with the expected queue,
   // then advance the queue by the handshakes that will happen at the next rising edge.
   always @(negedge clk) begin
      if (!reset) begin
         sb.delete();
      end else begin
         check("occupancy", N'(occupancy), N'(sb.size()));
         check("out_valid", N'(out_valid), N'(sb.size() != 0));
         check("in_ready", N'(in_ready), N'(sb.size() < 2));
         if (sb.size() != 0) check("out_data", out_data, sb[0]);
         m_in_fire  = in_valid && (sb.size() < 2);
         m_out_fire = (sb.size() != 0) && out_ready;
         if (flush) begin
            sb.delete();
         end else begin
            if (m_out_fire) void'(sb.pop_front());
            if (m_in_fire)  sb.push_back(in_data);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit           v, r, ir;
      int           bias;
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset values, during and after reset
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_data", out_data, RV);
      check("rst_out_valid", N'(out_valid), '0);
      check("rst_in_ready", N'(in_ready), N'(1));
      check("rst_occupancy", N'(occupancy), '0);
      reset = 1'b1;
      drive(0, '0, 0, 0);
      check("post_rst_out_data", out_data, RV);
      check("post_rst_in_ready", N'(in_ready), N'(1));
      check("post_rst_occupancy", N'(occupancy), '0);

      // Asynchronous reset mid-cycle while FULL
      drive(1, 32'h99, 0, 0);
      drive(0, '0, 0, 0);
      check("pre_async_occupancy", N'(occupancy), N'(1));
      #2 reset = 1'b0;
      #1;
      check("async_out_data", out_data, RV);
      check("async_out_valid", N'(out_valid), '0);
      check("async_in_ready", N'(in_ready), N'(1));
      check("async_occupancy", N'(occupancy), '0);
      @(posedge clk);
      #1 reset = 1'b1;

      // Streaming 01..10 with out_ready held high
      for (int i = 1; i <= 16; i++) begin
         drive(1, N'(i), 1, 0);
         if (i > 1) begin
            check("stream_out_data", out_data, N'(i - 1));
            check("stream_in_ready", N'(in_ready), N'(1));
            check("stream_occupancy", N'(occupancy), N'(1));
         end
      end
      drive(0, '0, 1, 0);
      check("stream_last", out_data, 32'h10);
      drive(0, '0, 1, 0);

      // Back-pressure fills the skid entry, then drains with no gap
      drive(1, 32'h11, 0, 0);
      drive(1, 32'h22, 0, 0);
      check("bp_occ_1", N'(occupancy), N'(1));
      drive(1, 32'h33, 0, 0);
      check("bp_occ_2", N'(occupancy), N'(2));
      check("bp_in_ready", N'(in_ready), '0);
      check("bp_head", out_data, 32'h11);
      drive(1, 32'h33, 1, 0);
      check("bp_hold_occ", N'(occupancy), N'(2));
      drive(1, 32'h33, 1, 0);
      check("bp_second", out_data, 32'h22);
      check("bp_ready_back", N'(in_ready), N'(1));
      drive(0, '0, 1, 0);
      check("bp_third", out_data, 32'h33);
      check("bp_third_valid", N'(out_valid), N'(1));
      drive(0, '0, 1, 0);
      check("bp_empty", N'(occupancy), '0);

      // Simultaneous in_fire and out_fire while FULL
      drive(1, 32'h40, 1, 0);
      drive(1, 32'h41, 1, 0);
      check("sim_head", out_data, 32'h40);
      drive(0, '0, 0, 0);
      check("sim_replace", out_data, 32'h41);
      check("sim_occupancy", N'(occupancy), N'(1));
      drive(0, '0, 1, 0);
      drive(0, '0, 1, 0);

      // Flush while in SKID with a pending upstream word
      drive(1, 32'h55, 0, 0);
      drive(1, 32'h66, 0, 0);
      drive(1, 32'h77, 0, 1);
      check("flush_pre_occ", N'(occupancy), N'(2));
      drive(0, '0, 0, 0);
      check("flush_out_valid", N'(out_valid), '0);
      check("flush_occupancy", N'(occupancy), '0);
      check("flush_in_ready", N'(in_ready), N'(1));
      check("flush_keeps_main", out_data, 32'h55);
      drive(0, '0, 1, 0);

      // Randomised traffic with varying back-pressure, rare flushes, X on idle data
      for (int c = 0; c < 10000; c++) begin
         bias = ((c / 1000) % 2 == 0) ? 3 : 1;
         v    = ($urandom_range(0, 3) != 0);
         r    = ($urandom_range(0, 3) < bias);
         @(posedge clk);
         #1;
         in_valid  = v;
         in_data   = v ? N'($urandom()) : 'x;
         out_ready = r;
         flush     = ($urandom_range(0, 63) == 0);
         if (c % 97 == 0) begin
            #1 ir = in_ready;
            out_ready = ~r;
            #1;
            check("in_ready_no_comb_path", N'(in_ready), N'(ir));
            out_ready = r;
         end
      end

      // Drain what is left, bounded
      drive(0, '0, 1, 0);
      for (int k = 0; k < 8 && sb.size() != 0; k++) drive(0, '0, 1, 0);
      drive(0, '0, 1, 0);
      check("drain_empty", N'(sb.size()), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
